opc_mem_arbiter: RTL and testbench

//  Shares one single-port synchronous 16-bit memory between two bus requesters:

---
 rtl/opc_mem_arbiter.sv | 89 ++++++++
 tb/tb_opc_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/opc_mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous memory.
// Round-robin or port-0 priority with a starvation guard; fixed-latency read return.
module opc_mem_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int RD_LAT       = 1,
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          rnw0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic          rnw1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  port_t             last_gnt;
  logic [7:0]        starve_cnt;
  logic              pick1;
  logic              issue_rd;
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_o;

  always_comb begin
    pick1 = 1'b0;
    if (req1 && !req0) begin
      pick1 = 1'b1;
    end else if (req0 && req1) begin
      if (PRIO_MODE == 0) pick1 = (last_gnt == PORT0);
      else                pick1 = (starve_cnt >= LIMIT);
    end
    gnt0      = !reset && req0 && !pick1;
    gnt1      = !reset && req1 && pick1;
    mem_ce    = gnt0 || gnt1;
    mem_addr  = gnt1 ? addr1 : addr0;
    mem_wdata = gnt1 ? wdata1 : wdata0;
    mem_we    = (gnt0 && !rnw0) || (gnt1 && !rnw1);
    issue_rd  = (gnt0 && rnw0) || (gnt1 && rnw1);
  end

  // Pipeline is registered; the reset gate here also masks stale entries
  // during the cycle in which reset is first asserted.
  assign rvalid0 = !reset && pipe_v[RD_LAT-1] && !pipe_o[RD_LAT-1];
  assign rvalid1 = !reset && pipe_v[RD_LAT-1] &&  pipe_o[RD_LAT-1];
  assign rdata0  = mem_rdata;
  assign rdata1  = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt   <= PORT1;
      starve_cnt <= '0;
      pipe_v     <= '0;
      pipe_o     <= '0;
    end else begin
      if (gnt1)      last_gnt <= PORT1;
      else if (gnt0) last_gnt <= PORT0;

      if (!req1 || gnt1)                    starve_cnt <= '0;
      else if (gnt0 && starve_cnt < LIMIT)  starve_cnt <= starve_cnt + 8'd1;

      pipe_v <= RD_LAT'({pipe_v, issue_rd});
      pipe_o <= RD_LAT'({pipe_o, gnt1});
    end
  end

endmodule

// File: tb/tb_opc_mem_arbiter.sv
// Directed bench for opc_mem_arbiter: three instances cover round-robin,
// priority with starvation guard (limit 3), and read latency 3.
module tb_opc_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, rnw0 = 1'b1, rnw1 = 1'b1;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;

  logic        a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_mem_ce, a_mem_we;
  logic [15:0] a_rdata0, a_rdata1, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_ce, b_mem_we;
  logic [15:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_wdata;
  logic        c_gnt0, c_gnt1, c_rvalid0, c_rvalid1, c_mem_ce, c_mem_we;
  logic [15:0] c_rdata0, c_rdata1, c_mem_addr, c_mem_wdata;
  logic [15:0] b_mem_rdata = 16'h0000;
  logic [15:0] c_mem_rdata = 16'hC0DE;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  opc_mem_arbiter dut_a (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .rnw0(rnw0), .wdata0(wdata0),
    .req1(req1), .addr1(addr1), .rnw1(rnw1), .wdata1(wdata1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .rvalid0(a_rvalid0), .rvalid1(a_rvalid1),
    .rdata0(a_rdata0), .rdata1(a_rdata1), .mem_ce(a_mem_ce), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  opc_mem_arbiter #(.PRIO_MODE(1), .STARVE_LIMIT(3)) dut_b (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .rnw0(rnw0), .wdata0(wdata0),
    .req1(req1), .addr1(addr1), .rnw1(rnw1), .wdata1(wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .rdata0(b_rdata0), .rdata1(b_rdata1), .mem_ce(b_mem_ce), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  opc_mem_arbiter #(.RD_LAT(3)) dut_c (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .rnw0(rnw0), .wdata0(wdata0),
    .req1(req1), .addr1(addr1), .rnw1(rnw1), .wdata1(wdata1),
    .gnt0(c_gnt0), .gnt1(c_gnt1), .rvalid0(c_rvalid0), .rvalid1(c_rvalid1),
    .rdata0(c_rdata0), .rdata1(c_rdata1), .mem_ce(c_mem_ce), .mem_we(c_mem_we),
    .mem_addr(c_mem_addr), .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata)
  );

  // Memory behind dut_a: unwritten locations read as 0x1000 + address.
  logic [15:0] mem [int];
  always @(posedge clk) begin
    if (a_mem_ce) begin
      if (a_mem_we) mem[int'(a_mem_addr)] = a_mem_wdata;
      else a_mem_rdata <= mem.exists(int'(a_mem_addr)) ? mem[int'(a_mem_addr)]
                                                        : 16'h1000 + a_mem_addr;
    end
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    next_cycle;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1; rnw0 = 1'b1; rnw1 = 1'b1;
    next_cycle;
    next_cycle;
    @(negedge clk);
    checks++; if (a_gnt0 !== 1'b0) $display("FAIL rst_gnt0 got=%b exp=0", a_gnt0); else passed++;
    checks++; if (a_gnt1 !== 1'b0) $display("FAIL rst_gnt1 got=%b exp=0", a_gnt1); else passed++;
    checks++; if (a_mem_ce !== 1'b0) $display("FAIL rst_ce got=%b exp=0", a_mem_ce); else passed++;
    checks++; if (a_mem_we !== 1'b0) $display("FAIL rst_we got=%b exp=0", a_mem_we); else passed++;
    checks++; if (a_rvalid0 !== 1'b0) $display("FAIL rst_rvalid0 got=%b exp=0", a_rvalid0); else passed++;
    checks++; if (a_rvalid1 !== 1'b0) $display("FAIL rst_rvalid1 got=%b exp=0", a_rvalid1); else passed++;
    checks++; if (b_gnt0 !== 1'b0) $display("FAIL rst_b_gnt0 got=%b exp=0", b_gnt0); else passed++;
    checks++; if (c_rvalid0 !== 1'b0) $display("FAIL rst_c_rvalid0 got=%b exp=0", c_rvalid0); else passed++;
    next_cycle;
  endtask

  task automatic test_first_read;
    reset = 1'b0; req0 = 1'b1; rnw0 = 1'b1; addr0 = 16'h0010; req1 = 1'b0;
    @(negedge clk);
    checks++; if (a_gnt0 !== 1'b1) $display("FAIL t1_gnt0 got=%b exp=1", a_gnt0); else passed++;
    checks++; if (a_gnt1 !== 1'b0) $display("FAIL t1_gnt1 got=%b exp=0", a_gnt1); else passed++;
    checks++; if (a_mem_ce !== 1'b1) $display("FAIL t1_ce got=%b exp=1", a_mem_ce); else passed++;
    checks++; if (a_mem_we !== 1'b0) $display("FAIL t1_we got=%b exp=0", a_mem_we); else passed++;
    checks++; if (a_mem_addr !== 16'h0010) $display("FAIL t1_addr got=%h exp=0010", a_mem_addr); else passed++;
    next_cycle;
    req0 = 1'b0;
    @(negedge clk);
    checks++; if (a_rvalid0 !== 1'b1) $display("FAIL t1_rvalid0 got=%b exp=1", a_rvalid0); else passed++;
    checks++; if (a_rdata0 !== 16'h1010) $display("FAIL t1_rdata0 got=%h exp=1010", a_rdata0); else passed++;
    checks++; if (a_rvalid1 !== 1'b0) $display("FAIL t1_rvalid1 got=%b exp=0", a_rvalid1); else passed++;
    next_cycle;
    @(negedge clk);
    checks++; if (a_rvalid0 !== 1'b0) $display("FAIL t1_rvalid0_end got=%b exp=0", a_rvalid0); else passed++;
    next_cycle;
  endtask

  task automatic test_round_robin;
    logic [5:0]  exp_w;
    logic [15:0] exp_a;
    exp_w = 6'b101010;
    do_reset;
    req0 = 1'b1; req1 = 1'b1; rnw0 = 1'b1; rnw1 = 1'b1;
    addr0 = 16'h0020; addr1 = 16'h0030;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_a = exp_w[k] ? 16'h0030 : 16'h0020;
      checks++; if (a_gnt0 !== !exp_w[k]) $display("FAIL rr_gnt0[%0d] got=%b exp=%b", k, a_gnt0, !exp_w[k]); else passed++;
      checks++; if (a_gnt1 !== exp_w[k]) $display("FAIL rr_gnt1[%0d] got=%b exp=%b", k, a_gnt1, exp_w[k]); else passed++;
      checks++; if (a_mem_ce !== 1'b1) $display("FAIL rr_ce[%0d] got=%b exp=1", k, a_mem_ce); else passed++;
      checks++; if (a_mem_addr !== exp_a) $display("FAIL rr_addr[%0d] got=%h exp=%h", k, a_mem_addr, exp_a); else passed++;
      if (k > 0) begin
        checks++; if (a_rvalid0 !== !exp_w[k-1]) $display("FAIL rr_rvalid0[%0d] got=%b exp=%b", k, a_rvalid0, !exp_w[k-1]); else passed++;
        checks++; if (a_rvalid1 !== exp_w[k-1]) $display("FAIL rr_rvalid1[%0d] got=%b exp=%b", k, a_rvalid1, exp_w[k-1]); else passed++;
        if (exp_w[k-1]) begin
          checks++; if (a_rdata1 !== 16'h1030) $display("FAIL rr_rdata1[%0d] got=%h exp=1030", k, a_rdata1); else passed++;
        end else begin
          checks++; if (a_rdata0 !== 16'h1020) $display("FAIL rr_rdata0[%0d] got=%h exp=1020", k, a_rdata0); else passed++;
        end
      end
      next_cycle;
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    checks++; if (a_rvalid1 !== 1'b1) $display("FAIL rr_tail_rvalid1 got=%b exp=1", a_rvalid1); else passed++;
    checks++; if (a_rvalid0 !== 1'b0) $display("FAIL rr_tail_rvalid0 got=%b exp=0", a_rvalid0); else passed++;
    checks++; if (a_mem_ce !== 1'b0) $display("FAIL rr_tail_ce got=%b exp=0", a_mem_ce); else passed++;
    next_cycle;
  endtask

  task automatic test_priority_starve;
    logic [7:0] exp_w;
    exp_w = 8'b10001000;
    do_reset;
    req0 = 1'b1; req1 = 1'b1; rnw0 = 1'b1; rnw1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++; if (b_gnt0 !== !exp_w[k]) $display("FAIL pr_gnt0[%0d] got=%b exp=%b", k, b_gnt0, !exp_w[k]); else passed++;
      checks++; if (b_gnt1 !== exp_w[k]) $display("FAIL pr_gnt1[%0d] got=%b exp=%b", k, b_gnt1, exp_w[k]); else passed++;
      checks++; if (b_mem_ce !== 1'b1) $display("FAIL pr_ce[%0d] got=%b exp=1", k, b_mem_ce); else passed++;
      next_cycle;
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_write_then_read;
    do_reset;
    req0 = 1'b1; rnw0 = 1'b0; addr0 = 16'h0100; wdata0 = 16'hBEEF; req1 = 1'b0;
    @(negedge clk);
    checks++; if (a_gnt0 !== 1'b1) $display("FAIL wr_gnt0 got=%b exp=1", a_gnt0); else passed++;
    checks++; if (a_mem_we !== 1'b1) $display("FAIL wr_we got=%b exp=1", a_mem_we); else passed++;
    checks++; if (a_mem_wdata !== 16'hBEEF) $display("FAIL wr_wdata got=%h exp=beef", a_mem_wdata); else passed++;
    checks++; if (a_mem_addr !== 16'h0100) $display("FAIL wr_addr got=%h exp=0100", a_mem_addr); else passed++;
    next_cycle;
    req0 = 1'b0; req1 = 1'b1; rnw1 = 1'b1; addr1 = 16'h0100;
    @(negedge clk);
    checks++; if (a_gnt1 !== 1'b1) $display("FAIL rd_gnt1 got=%b exp=1", a_gnt1); else passed++;
    checks++; if (a_mem_we !== 1'b0) $display("FAIL rd_we got=%b exp=0", a_mem_we); else passed++;
    checks++; if (a_rvalid0 !== 1'b0) $display("FAIL wr_no_rvalid0 got=%b exp=0", a_rvalid0); else passed++;
    next_cycle;
    req1 = 1'b0;
    @(negedge clk);
    checks++; if (a_rvalid1 !== 1'b1) $display("FAIL rd_rvalid1 got=%b exp=1", a_rvalid1); else passed++;
    checks++; if (a_rdata1 !== 16'hBEEF) $display("FAIL rd_rdata1 got=%h exp=beef", a_rdata1); else passed++;
    checks++; if (a_rvalid0 !== 1'b0) $display("FAIL rd_rvalid0 got=%b exp=0", a_rvalid0); else passed++;
    next_cycle;
    @(negedge clk);
    checks++; if (a_rvalid1 !== 1'b0) $display("FAIL rd_rvalid1_end got=%b exp=0", a_rvalid1); else passed++;
    next_cycle;
  endtask

  task automatic test_reset_inflight;
    do_reset;
    req0 = 1'b1; rnw0 = 1'b1; addr0 = 16'h0040; req1 = 1'b0;
    @(negedge clk);
    checks++; if (c_gnt0 !== 1'b1) $display("FAIL rf_c0_gnt0 got=%b exp=1", c_gnt0); else passed++;
    checks++; if (c_rvalid0 !== 1'b0) $display("FAIL rf_c0_rvalid0 got=%b exp=0", c_rvalid0); else passed++;
    next_cycle;
    req0 = 1'b0; req1 = 1'b1; rnw1 = 1'b1; addr1 = 16'h0041;
    @(negedge clk);
    checks++; if (c_gnt1 !== 1'b1) $display("FAIL rf_c1_gnt1 got=%b exp=1", c_gnt1); else passed++;
    next_cycle;
    req0 = 1'b1; req1 = 1'b0;
    @(negedge clk);
    checks++; if (c_gnt0 !== 1'b1) $display("FAIL rf_c2_gnt0 got=%b exp=1", c_gnt0); else passed++;
    next_cycle;
    reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    checks++; if (c_gnt0 !== 1'b0) $display("FAIL rf_c3_gnt0 got=%b exp=0", c_gnt0); else passed++;
    checks++; if (c_gnt1 !== 1'b0) $display("FAIL rf_c3_gnt1 got=%b exp=0", c_gnt1); else passed++;
    checks++; if (c_mem_ce !== 1'b0) $display("FAIL rf_c3_ce got=%b exp=0", c_mem_ce); else passed++;
    checks++; if (c_rvalid0 !== 1'b0) $display("FAIL rf_c3_rvalid0 got=%b exp=0", c_rvalid0); else passed++;
    checks++; if (c_rvalid1 !== 1'b0) $display("FAIL rf_c3_rvalid1 got=%b exp=0", c_rvalid1); else passed++;
    next_cycle;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (c_gnt0 !== 1'b1) $display("FAIL rf_c4_gnt0 got=%b exp=1", c_gnt0); else passed++;
    checks++; if (c_gnt1 !== 1'b0) $display("FAIL rf_c4_gnt1 got=%b exp=0", c_gnt1); else passed++;
    checks++; if (c_rvalid0 !== 1'b0) $display("FAIL rf_c4_rvalid0 got=%b exp=0", c_rvalid0); else passed++;
    checks++; if (c_rvalid1 !== 1'b0) $display("FAIL rf_c4_rvalid1 got=%b exp=0", c_rvalid1); else passed++;
    next_cycle;
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 5; k < 7; k++) begin
      @(negedge clk);
      checks++; if (c_rvalid0 !== 1'b0) $display("FAIL rf_c%0d_rvalid0 got=%b exp=0", k, c_rvalid0); else passed++;
      checks++; if (c_rvalid1 !== 1'b0) $display("FAIL rf_c%0d_rvalid1 got=%b exp=0", k, c_rvalid1); else passed++;
      next_cycle;
    end
    @(negedge clk);
    checks++; if (c_rvalid0 !== 1'b1) $display("FAIL rf_c7_rvalid0 got=%b exp=1", c_rvalid0); else passed++;
    checks++; if (c_rdata0 !== 16'hC0DE) $display("FAIL rf_c7_rdata0 got=%h exp=c0de", c_rdata0); else passed++;
    checks++; if (c_rvalid1 !== 1'b0) $display("FAIL rf_c7_rvalid1 got=%b exp=0", c_rvalid1); else passed++;
    next_cycle;
  endtask

  task automatic test_toggle_mixed;
    logic [8:0]  req_pat, rnw_pat, exp_rv;
    logic [15:0] t_addr [9];
    logic [15:0] t_wdata [9];
    logic [15:0] exp_rd [9];
    int          nrv;
    req_pat = 9'b001101101;
    rnw_pat = 9'b001100100;
    exp_rv  = 9'b011001000;
    t_addr  = '{16'h0200, 16'h0000, 16'h0200, 16'h0201, 16'h0000, 16'h0201, 16'h0050, 16'h0000, 16'h0000};
    t_wdata = '{16'h1111, 16'h0000, 16'h0000, 16'h2222, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    exp_rd  = '{16'h0000, 16'h0000, 16'h0000, 16'h1111, 16'h0000, 16'h0000, 16'h2222, 16'h1050, 16'h0000};
    nrv = 0;
    do_reset;
    req0 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      req1 = req_pat[k]; rnw1 = rnw_pat[k]; addr1 = t_addr[k]; wdata1 = t_wdata[k];
      @(negedge clk);
      checks++; if (a_gnt1 !== req_pat[k]) $display("FAIL tg_gnt1[%0d] got=%b exp=%b", k, a_gnt1, req_pat[k]); else passed++;
      checks++; if (a_mem_we !== (req_pat[k] & ~rnw_pat[k])) $display("FAIL tg_we[%0d] got=%b exp=%b", k, a_mem_we, req_pat[k] & ~rnw_pat[k]); else passed++;
      checks++; if (a_rvalid1 !== exp_rv[k]) $display("FAIL tg_rvalid1[%0d] got=%b exp=%b", k, a_rvalid1, exp_rv[k]); else passed++;
      checks++; if (a_rvalid0 !== 1'b0) $display("FAIL tg_rvalid0[%0d] got=%b exp=0", k, a_rvalid0); else passed++;
      if (exp_rv[k]) begin
        checks++; if (a_rdata1 !== exp_rd[k]) $display("FAIL tg_rdata1[%0d] got=%h exp=%h", k, a_rdata1, exp_rd[k]); else passed++;
      end
      if (a_rvalid1 === 1'b1) nrv++;
      next_cycle;
    end
    checks++; if (nrv !== 3) $display("FAIL tg_rvalid_count got=%0d exp=3", nrv); else passed++;
  endtask

  initial begin
    test_reset;
    test_first_read;
    test_round_robin;
    test_priority_starve;
    test_write_then_read;
    test_reset_inflight;
    test_toggle_mixed;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
